// File: rtl/response_framer.sv
// Response framer: buffers handler parameter words and emits LEN, CODE, params, CRC-8
// as a byte stream, and arbitrates involuntary response slots.
module response_framer #(
    parameter int NPARAM_MAX = 16,
    parameter int RSP_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [32:0] param_data,
    input  logic        param_write,
    input  logic        cmd_done,
    input  logic        cmd_active,
    input  logic        invol_req,
    output logic        invol_grant,
    output logic        rsp_busy,
    output logic [7:0]  msg_data,
    output logic        msg_valid,
    input  logic        msg_ready,
    output logic        overflow,
    output logic        proto_err
);

    localparam int IW    = $clog2(NPARAM_MAX + 1);
    localparam int DEPTH = 1 << IW;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COLLECT    = 3'd1,
        EMIT_LEN   = 3'd2,
        EMIT_CODE  = 3'd3,
        EMIT_PARAM = 3'd4,
        EMIT_CRC   = 3'd5
    } state_t;

    state_t        state_r;
    logic [32:0]   buf_r [0:DEPTH-1];
    logic [IW-1:0] cnt_r;
    logic [IW-1:0] rd_idx_r;
    logic [1:0]    byte_idx_r;
    logic [7:0]    pay_r;
    logic [7:0]    code_r;
    logic [7:0]    crc_r;
    logic [7:0]    data_r;
    logic          valid_r;
    logic          grant_r;
    logic          ovf_r;
    logic          perr_r;

    logic          accepting_s;
    logic          store_s;
    logic [7:0]    add_s;
    logic [7:0]    pay_next_s;
    logic          handshake_s;
    logic [7:0]    crc_next_s;
    logic          last_in_word_s;
    logic [IW-1:0] next_idx_s;

    // CRC-8, polynomial 0x07, MSB-first, one byte per call
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ 8'h07;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    // Byte idx of a stored word: flagged words are one byte, others big-endian 32-bit
    function automatic logic [7:0] word_byte(input logic [32:0] w, input logic [1:0] idx);
        logic [7:0] b;
        if (w[32]) begin
            b = w[7:0];
        end else begin
            case (idx)
                2'd0:    b = w[31:24];
                2'd1:    b = w[23:16];
                2'd2:    b = w[15:8];
                default: b = w[7:0];
            endcase
        end
        return b;
    endfunction

    // Next-state helpers: store qualification, payload count, CRC and word walk
    always_comb begin
        accepting_s = (state_r == IDLE) || (state_r == COLLECT);
        store_s     = accepting_s && param_write && (cnt_r < IW'(NPARAM_MAX));
        if (param_data[32]) begin
            add_s = 8'd1;
        end else begin
            add_s = 8'd4;
        end
        if (store_s) begin
            pay_next_s = pay_r + add_s;
        end else begin
            pay_next_s = pay_r;
        end
        handshake_s    = valid_r && msg_ready;
        crc_next_s     = crc8_byte(crc_r, data_r);
        last_in_word_s = buf_r[rd_idx_r][32] || (byte_idx_r == 2'd3);
        next_idx_s     = rd_idx_r + IW'(1);
    end

    // Parameter buffer; depth is padded to a power of two so every index is in range
    always_ff @(posedge clk) begin
        if (store_s) begin
            buf_r[cnt_r] <= param_data;
        end
    end

    // Framer FSM, involuntary grant and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            rd_idx_r   <= '0;
            byte_idx_r <= 2'd0;
            pay_r      <= 8'd0;
            code_r     <= 8'd0;
            crc_r      <= 8'd0;
            data_r     <= 8'd0;
            valid_r    <= 1'b0;
            grant_r    <= 1'b0;
            ovf_r      <= 1'b0;
            perr_r     <= 1'b0;
        end else begin
            grant_r <= invol_req && (state_r == IDLE) && !cmd_active && !grant_r;
            if (!accepting_s && (param_write || cmd_done)) begin
                perr_r <= 1'b1;
            end
            case (state_r)
                IDLE, COLLECT: begin
                    if (param_write && !store_s) begin
                        ovf_r <= 1'b1;
                    end
                    if (store_s) begin
                        cnt_r <= cnt_r + IW'(1);
                    end
                    pay_r <= pay_next_s;
                    if (cmd_done) begin
                        code_r  <= 8'(param_data[RSP_BITS-1:0]);
                        data_r  <= pay_next_s + 8'd3;
                        valid_r <= 1'b1;
                        state_r <= EMIT_LEN;
                    end else if (param_write) begin
                        state_r <= COLLECT;
                    end
                end
                EMIT_LEN: begin
                    if (handshake_s) begin
                        crc_r   <= crc_next_s;
                        data_r  <= code_r;
                        state_r <= EMIT_CODE;
                    end
                end
                EMIT_CODE: begin
                    if (handshake_s) begin
                        crc_r <= crc_next_s;
                        if (cnt_r == '0) begin
                            data_r  <= crc_next_s;
                            state_r <= EMIT_CRC;
                        end else begin
                            rd_idx_r   <= '0;
                            byte_idx_r <= 2'd0;
                            data_r     <= word_byte(buf_r[0], 2'd0);
                            state_r    <= EMIT_PARAM;
                        end
                    end
                end
                EMIT_PARAM: begin
                    if (handshake_s) begin
                        crc_r <= crc_next_s;
                        if (last_in_word_s) begin
                            if (next_idx_s == cnt_r) begin
                                data_r  <= crc_next_s;
                                state_r <= EMIT_CRC;
                            end else begin
                                rd_idx_r   <= next_idx_s;
                                byte_idx_r <= 2'd0;
                                data_r     <= word_byte(buf_r[next_idx_s], 2'd0);
                            end
                        end else begin
                            byte_idx_r <= byte_idx_r + 2'd1;
                            data_r     <= word_byte(buf_r[rd_idx_r], byte_idx_r + 2'd1);
                        end
                    end
                end
                EMIT_CRC: begin
                    if (handshake_s) begin
                        valid_r <= 1'b0;
                        data_r  <= 8'd0;
                        cnt_r   <= '0;
                        pay_r   <= 8'd0;
                        crc_r   <= 8'd0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign invol_grant = grant_r;
    assign rsp_busy    = (state_r != IDLE) || grant_r;
    assign msg_data    = data_r;
    assign msg_valid   = valid_r;
    assign overflow    = ovf_r;
    assign proto_err   = perr_r;

endmodule

// File: tb/tb_response_framer.sv
// Scoreboard bench for response_framer: a reference model queues expected frame bytes,
// a negedge monitor pops and compares them on every handshake.
module tb_response_framer;

    localparam int NP = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [32:0] param_data = 33'd0;
    logic        param_write = 1'b0;
    logic        cmd_done = 1'b0;
    logic        cmd_active = 1'b0;
    logic        invol_req = 1'b0;
    logic        invol_grant;
    logic        rsp_busy;
    logic [7:0]  msg_data;
    logic        msg_valid;
    logic        msg_ready = 1'b1;
    logic        overflow;
    logic        proto_err;

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [32:0] mw[$];
    bit          mon_en = 1'b0;
    bit          rdy_mode = 1'b0;
    bit          stalled = 1'b0;
    logic [7:0]  held;

    response_framer #(.NPARAM_MAX(NP), .RSP_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .param_data(param_data), .param_write(param_write),
        .cmd_done(cmd_done), .cmd_active(cmd_active), .invol_req(invol_req),
        .invol_grant(invol_grant), .rsp_busy(rsp_busy), .msg_data(msg_data),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .overflow(overflow),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_crc(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic model_frame(input logic [7:0] code);
        logic [7:0] b[$];
        logic [7:0] crc;
        int         n;
        int         pay;
        n   = (mw.size() > NP) ? NP : mw.size();
        pay = 0;
        for (int i = 0; i < n; i++) pay += mw[i][32] ? 1 : 4;
        b.push_back(8'(pay + 3));
        b.push_back(code);
        for (int i = 0; i < n; i++) begin
            if (mw[i][32]) begin
                b.push_back(mw[i][7:0]);
            end else begin
                b.push_back(mw[i][31:24]);
                b.push_back(mw[i][23:16]);
                b.push_back(mw[i][15:8]);
                b.push_back(mw[i][7:0]);
            end
        end
        crc = 8'h00;
        foreach (b[k]) crc = ref_crc(crc, b[k]);
        b.push_back(crc);
        foreach (b[k]) exp_q.push_back(b[k]);
        mw.delete();
    endtask

    task automatic pw(input logic [32:0] w);
        mw.push_back(w);
        param_data  = w;
        param_write = 1'b1;
        @(posedge clk); #1;
        param_write = 1'b0;
    endtask

    task automatic close_frame(input logic [7:0] code, input bit use_model);
        if (use_model) model_frame(code);
        param_data = {25'd0, code};
        cmd_done   = 1'b1;
        @(posedge clk); #1;
        cmd_done   = 1'b0;
        check("len_valid", {31'd0, msg_valid}, 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && (exp_q.size() != 0 || rsp_busy); i++) begin
            @(posedge clk); #1;
        end
        check(tag, exp_q.size(), 32'd0);
        check({tag, "_busy"}, {31'd0, rsp_busy}, 32'd0);
    endtask

    // Ready driver: constant high or random stalls
    initial begin
        forever begin
            @(posedge clk); #1;
            msg_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: byte compare on handshake and hold check while stalled
    always @(negedge clk) begin
        if (!mon_en) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", {31'd0, msg_valid}, 32'd1);
                check("hold_data", {24'd0, msg_data}, {24'd0, held});
            end
            if (msg_valid && msg_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", {24'd0, msg_data}, 32'hFFFF_FFFF);
                end else begin
                    check("byte", {24'd0, msg_data}, {24'd0, exp_q.pop_front()});
                end
                stalled = 1'b0;
            end else if (msg_valid) begin
                stalled = 1'b1;
                held    = msg_data;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", {31'd0, invol_grant}, 32'd0);
        check("rst_busy", {31'd0, rsp_busy}, 32'd0);
        check("rst_valid", {31'd0, msg_valid}, 32'd0);
        check("rst_data", {24'd0, msg_data}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_perr", {31'd0, proto_err}, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Single parameter, exact cycle count with ready held high
        pw(33'h0_1234_5678);
        close_frame(8'h05, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("t1_crc_valid", {31'd0, msg_valid}, 32'd1);
        @(posedge clk); #1;
        check("t1_done_valid", {31'd0, msg_valid}, 32'd0);
        check("t1_done_busy", {31'd0, rsp_busy}, 32'd0);
        drain("t1_drain");

        // Five 32-bit parameters, without and then with stalls
        for (int pass = 0; pass < 2; pass++) begin
            rdy_mode = (pass == 1);
            for (int i = 0; i < 5; i++) pw({1'b0, 32'hA000_0000 + 32'(i * 32'h0101_0101)});
            close_frame(8'h01, 1'b1);
            drain("t2_drain");
        end
        rdy_mode = 1'b0;

        // Mixed encoding
        pw(33'h1_0000_00AB);
        pw(33'h0_0000_0001);
        close_frame(8'h10, 1'b1);
        drain("t3_drain");

        // Overflow: NP+2 words, alternating encodings
        check("ovf_before", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < NP + 2; i++) pw({1'(i % 2), 32'h5A00_0000 + 32'(i)});
        close_frame(8'h42, 1'b1);
        drain("t4_drain");
        check("ovf_after", {31'd0, overflow}, 32'd1);

        // Arbitration
        cmd_active = 1'b1;
        invol_req  = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_grant_active", {31'd0, invol_grant}, 32'd0);
        end
        cmd_active = 1'b0;
        @(posedge clk); #1;
        check("grant_pulse", {31'd0, invol_grant}, 32'd1);
        check("grant_busy", {31'd0, rsp_busy}, 32'd1);
        invol_req = 1'b0;
        @(posedge clk); #1;
        check("grant_single", {31'd0, invol_grant}, 32'd0);
        check("perr_before", {31'd0, proto_err}, 32'd0);
        pw(33'h0_CAFE_F00D);
        pw(33'h1_0000_0077);
        close_frame(8'h20, 1'b1);
        param_data  = 33'h0_DEAD_BEEF;
        param_write = 1'b1;
        @(posedge clk); #1;
        param_write = 1'b0;
        check("perr_after", {31'd0, proto_err}, 32'd1);
        drain("t5_drain");

        // Reset during EMIT_PARAM, then a zero-parameter frame
        for (int i = 0; i < 3; i++) pw({1'b0, 32'h1111_1111 * 32'(i + 1)});
        close_frame(8'h07, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_valid", {31'd0, msg_valid}, 32'd0);
        check("rst_mid_ovf", {31'd0, overflow}, 32'd0);
        check("rst_mid_perr", {31'd0, proto_err}, 32'd0);
        check("rst_mid_busy", {31'd0, rsp_busy}, 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h36);
        close_frame(8'h03, 1'b0);
        drain("t6_drain");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
